// File: rtl/seg_scan_capture_pkg.sv
// seg_scan_capture_pkg: glyph encodings, digit codes and capture FSM states
package seg_scan_capture_pkg;
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR = 4'hE;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg_scan_capture_glyph_dec.sv
// seg_glyph_dec: inverse seven-segment decoder, pattern to digit code plus error flag
module seg_glyph_dec
  import seg_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);
  always_comb begin
    err = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed 6-digit 7-seg bus and rebuilds frames and value
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_vld,
  output logic [5:0]  o_value,
  output logic        o_value_vld,
  output logic        o_glyph_err,
  output logic        o_enb_err,
  output logic        o_stale
);
  logic [6:0] seg_s1, seg_s2;
  logic dp_s1, dp_s2;
  logic [5:0] enb_s1, enb_s2;
  logic [13:0] prev;
  state_t state, state_nx;
  logic [31:0] cnt, cnt_nx, tcnt;
  logic [5:0] seen, seen_nx, stg_dp, dp_nx;
  logic [23:0] stg, stg_nx;
  logic [2:0] idx;
  logic blank, valid, changed, enb_chg, capture, done, gerr, vok;
  logic [3:0] code, d1, d0;
  logic [5:0] val;
  seg_glyph_dec u_dec (.seg(seg_s2), .code(code), .err(gerr));
  assign blank   = enb_s2 == 6'h3F;
  assign valid   = $onehot(~enb_s2);
  assign changed = {enb_s2, seg_s2, dp_s2} != prev;
  assign enb_chg = enb_s2 != prev[13:8];
  assign o_stale = tcnt == 32'(TIMEOUT_CYC);
  always_comb begin
    idx = '0;
    for (int i = 0; i < 6; i++) idx = enb_s2[i] ? idx : 3'(i);
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    capture = 1'b0;
    case (state)
      IDLE: if (valid) begin
        state_nx = SETTLE;
        cnt_nx = '0;
      end
      SETTLE:
        if (!valid) state_nx = IDLE;
        else if (changed) cnt_nx = '0;
        else if (cnt == 32'(SETTLE_CYC - 1)) begin
          capture = 1'b1;
          state_nx = HOLD;
        end else cnt_nx = cnt + 32'd1;
      HOLD: if (enb_chg) begin
        state_nx = valid ? SETTLE : IDLE;
        cnt_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  // staging view including this cycle's capture, so completion sees the new digit
  always_comb begin
    stg_nx = stg;
    dp_nx = stg_dp;
    for (int i = 0; i < 6; i++)
      if (capture && idx == 3'(i)) begin
        stg_nx[4*i +: 4] = code;
        dp_nx[i] = dp_s2;
      end
  end
  assign seen_nx = capture ? seen | (6'b1 << idx) : seen;
  assign done = capture && &seen_nx;
  assign d1 = stg_nx[7:4];
  assign d0 = stg_nx[3:0];
  assign vok = d1 <= 4'd5 && d0 <= 4'd9;
  assign val = 6'(d1) * 6'd10 + 6'(d0);
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dp_s1 <= 1'b0;
      dp_s2 <= 1'b0;
      enb_s1 <= '1;
      enb_s2 <= '1;
      prev <= {6'h3F, 8'h00};
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      seen <= '0;
      stg <= '1;
      stg_dp <= '0;
      o_digits <= '1;
      o_dp <= '0;
      o_frame_vld <= 1'b0;
      o_value <= '0;
      o_value_vld <= 1'b0;
      o_glyph_err <= 1'b0;
      o_enb_err <= 1'b0;
    end else begin
      seg_s1 <= i_seg;
      seg_s2 <= seg_s1;
      dp_s1 <= i_seg_dp;
      dp_s2 <= dp_s1;
      enb_s1 <= i_seg_enb;
      enb_s2 <= enb_s1;
      prev <= {enb_s2, seg_s2, dp_s2};
      state <= state_nx;
      cnt <= cnt_nx;
      tcnt <= capture ? '0 : o_stale ? tcnt : tcnt + 32'd1;
      seen <= done ? '0 : seen_nx;
      stg <= stg_nx;
      stg_dp <= dp_nx;
      o_frame_vld <= done;
      if (done) begin
        o_digits <= stg_nx;
        o_dp <= dp_nx;
        o_value_vld <= vok;
        if (vok) o_value <= val;
      end
      o_glyph_err <= o_glyph_err | (capture & gerr);
      o_enb_err <= o_enb_err | (!blank & !valid);
    end
  end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scans with a frame scoreboard and flag checks
module tb_seg_scan_capture;
  localparam int TO = 300;
  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  value;
    logic        vld;
  } frame_t;
  logic clk = 0, rst = 1;
  logic [6:0] i_seg = '0;
  logic i_seg_dp = 0;
  logic [5:0] i_seg_enb = '1;
  logic [23:0] o_digits;
  logic [5:0] o_dp, o_value;
  logic o_frame_vld, o_value_vld, o_glyph_err, o_enb_err, o_stale;
  int tests = 0, fails = 0;
  frame_t exp_q[$];
  seg_scan_capture #(.SETTLE_CYC(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
    .o_digits(o_digits), .o_dp(o_dp), .o_frame_vld(o_frame_vld), .o_value(o_value),
    .o_value_vld(o_value_vld), .o_glyph_err(o_glyph_err), .o_enb_err(o_enb_err),
    .o_stale(o_stale)
  );
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && o_frame_vld) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL frame: unexpected frame digits=%h dp=%b", o_digits, o_dp);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        if ({o_digits, o_dp, o_value, o_value_vld} !== e) begin
          fails++;
          $display("FAIL frame: got digits=%h dp=%b value=%0d vld=%b expected digits=%h dp=%b value=%0d vld=%b",
                   o_digits, o_dp, o_value, o_value_vld, e.digits, e.dp, e.value, e.vld);
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive_one(input int k, input logic [6:0] s, input logic d);
    i_seg_enb = ~(6'b1 << k);
    i_seg_dp = d;
    i_seg = s;
    cyc(30);
    i_seg_enb = '1;
    i_seg = '0;
    i_seg_dp = 0;
    cyc(4);
  endtask
  task automatic scan(input logic [41:0] segs, input logic [5:0] dps, input bit glitch, input logic [6:0] gseg);
    for (int k = 5; k >= 0; k--) begin
      if (glitch && k == 0) begin
        i_seg_enb = 6'b111110;
        i_seg_dp = dps[0];
        i_seg = gseg;
        cyc(5);
      end
      drive_one(k, segs[7*k +: 7], dps[k]);
    end
  endtask
  localparam logic [41:0] S37 = {7'h00, 7'h00, 7'h00, 7'h00, 7'h79, 7'h70};
  initial begin
    cyc(3);
    chk("rst_digits", 32'(o_digits), 32'hFFFFFF);
    chk("rst_dp", 32'(o_dp), 0);
    chk("rst_frame_vld", 32'(o_frame_vld), 0);
    chk("rst_value", 32'(o_value), 0);
    chk("rst_value_vld", 32'(o_value_vld), 0);
    chk("rst_glyph_err", 32'(o_glyph_err), 0);
    chk("rst_enb_err", 32'(o_enb_err), 0);
    chk("rst_stale", 32'(o_stale), 0);
    rst = 0;
    cyc(2);
    exp_q.push_back('{24'hFFFF37, 6'b0, 6'd37, 1'b1});
    scan(S37, 6'b0, 0, 7'h00);
    exp_q.push_back('{24'hFFFF37, 6'b0, 6'd37, 1'b1});
    scan(S37, 6'b0, 0, 7'h00);
    exp_q.push_back('{24'hFFFF45, 6'b001000, 6'd45, 1'b1});
    scan({7'h00, 7'h00, 7'h00, 7'h00, 7'h33, 7'h5B}, 6'b001000, 1, 7'h6D);
    chk("enb_err_before", 32'(o_enb_err), 0);
    i_seg_enb = 6'b111100;
    i_seg = 7'h30;
    cyc(20);
    i_seg_enb = '1;
    i_seg = '0;
    cyc(4);
    chk("enb_err_set", 32'(o_enb_err), 1);
    exp_q.push_back('{24'hFFFF37, 6'b0, 6'd37, 1'b1});
    scan(S37, 6'b0, 0, 7'h00);
    exp_q.push_back('{24'hFFFE72, 6'b0, 6'd37, 1'b0});
    scan({7'h00, 7'h00, 7'h00, 7'h01, 7'h70, 7'h6D}, 6'b0, 0, 7'h00);
    chk("glyph_err_set", 32'(o_glyph_err), 1);
    chk("enb_err_sticky", 32'(o_enb_err), 1);
    cyc(100);
    chk("stale_early", 32'(o_stale), 0);
    cyc(250);
    chk("stale_set", 32'(o_stale), 1);
    drive_one(0, 7'h7E, 0);
    chk("stale_clear", 32'(o_stale), 0);
    drive_one(1, 7'h7E, 0);
    drive_one(2, 7'h7E, 0);
    rst = 1;
    cyc(2);
    rst = 0;
    cyc(1);
    chk("rst2_digits", 32'(o_digits), 32'hFFFFFF);
    chk("rst2_value", 32'(o_value), 0);
    chk("rst2_glyph_err", 32'(o_glyph_err), 0);
    chk("rst2_enb_err", 32'(o_enb_err), 0);
    exp_q.push_back('{24'h016958, 6'b000001, 6'd58, 1'b1});
    scan({7'h7E, 7'h30, 7'h5F, 7'h73, 7'h5B, 7'h7F}, 6'b000001, 0, 7'h00);
    cyc(20);
    chk("frames_pending", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
